// File: rtl/word_serializer_pkg.sv
// serializer_pkg: shared helpers and encodings for the word serializer slice.
//   clog2     - ceil(log2(v)), 0 for v<=1; constant-foldable for parameters
//   cntWidth  - symbol counter width for a given RATIO (at least 1 bit)
//   ORDER_MSB / ORDER_LSB - iMsbFirst encodings
package serializer_pkg;

    localparam logic ORDER_MSB = 1'b1;
    localparam logic ORDER_LSB = 1'b0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int cntWidth(input int ratio);
        return (clog2(ratio) < 1) ? 1 : clog2(ratio);
    endfunction

endpackage

// File: rtl/word_serializer_if.sv
// word_serializer_if: word-in / symbol-out handshake bundle.
//   master: producer of words + consumer of symbols (drives iData, iMsbFirst,
//           iValid, iFlush, oReady)
//   slave : the serializer (drives iReady, oData, oValid, oLast, oLevel)
interface word_serializer_if
    import serializer_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4
);
    localparam int LVL_W = clog2(DEPTH) + 1;

    logic [IN_W-1:0]  iData;
    logic             iMsbFirst;
    logic             iValid;
    logic             iReady;
    logic             iFlush;
    logic [OUT_W-1:0] oData;
    logic             oValid;
    logic             oReady;
    logic             oLast;
    logic [LVL_W-1:0] oLevel;

    modport master (
        output iData, iMsbFirst, iValid, iFlush, oReady,
        input  iReady, oData, oValid, oLast, oLevel
    );

    modport slave (
        input  iData, iMsbFirst, iValid, iFlush, oReady,
        output iReady, oData, oValid, oLast, oLevel
    );

endinterface

// File: rtl/word_fifo.sv
// word_fifo: DEPTH x W synchronous FIFO with flush and occupancy count.
//   clk, rst (async, active-low)
//   push/wData : write wData at the tail (caller guarantees not full)
//   pop        : drop the head (caller guarantees not empty)
//   flush      : empty the FIFO; overrides push/pop in the same cycle
//   rData      : current head entry (valid when count != 0)
//   count      : entries held, 0..DEPTH
module word_fifo
    import serializer_pkg::*;
#(
    parameter  int W     = 33,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wData,
    output logic [W-1:0] rData,
    output logic [AW:0]  count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wrPtr] <= wData;
    end

    assign rData = mem[rdPtr];

endmodule

// File: rtl/word_serializer.sv
// word_serializer: queues IN_W-bit words and emits them as RATIO = IN_W/OUT_W
// OUT_W-bit symbols, MS-first or LS-first per word.
//   clk, rst (async, active-low)
//   bus.slave : iData/iMsbFirst/iValid/iReady word input, iFlush,
//               oData/oValid/oReady/oLast symbol output, oLevel FIFO words
// The FIFO head is loaded into a shift stage as the previous word's last
// symbol is accepted, so back-to-back words stream without a bubble.
module word_serializer
    import serializer_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    word_serializer_if.slave bus
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int CNT_W = cntWidth(RATIO);
    localparam int LVL_W = clog2(DEPTH) + 1;

    generate
        if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : gBadRatio
            $error("word_serializer: IN_W must be a multiple of OUT_W with RATIO >= 2");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
            $error("word_serializer: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [LVL_W-1:0] level;
    logic [IN_W:0]    head;      // {msbFirst, word}
    logic [IN_W-1:0]  word;
    logic             msbFirst;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             pop;
    logic             push;

    // Symbol k of w in the requested order.
    function automatic logic [OUT_W-1:0] pick(input logic [IN_W-1:0] w,
                                              input logic msb,
                                              input logic [CNT_W-1:0] k);
        int sh;
        sh = (msb == ORDER_MSB) ? (RATIO - 1 - int'(k)) * OUT_W : int'(k) * OUT_W;
        return OUT_W'(w >> sh);
    endfunction

    // iReady depends on the registered level only (no path from oReady).
    assign bus.iReady = (level != LVL_W'(DEPTH));
    assign bus.oLevel = level;

    assign accept = bus.oValid && bus.oReady;
    assign pop    = (level != '0) && (!bus.oValid || (accept && bus.oLast)) && !bus.iFlush;
    assign push   = bus.iValid && bus.iReady && !bus.iFlush;

    word_fifo #(.W(IN_W + 1), .DEPTH(DEPTH)) uFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.iFlush),
        .wData ({bus.iMsbFirst, bus.iData}),
        .rData (head),
        .count (level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word       <= '0;
            msbFirst   <= 1'b0;
            cnt        <= '0;
            bus.oValid <= 1'b0;
            bus.oData  <= '0;
            bus.oLast  <= 1'b0;
        end else if (bus.iFlush) begin
            cnt        <= '0;
            bus.oValid <= 1'b0;
            bus.oData  <= '0;
            bus.oLast  <= 1'b0;
        end else if (pop) begin
            word       <= head[IN_W-1:0];
            msbFirst   <= head[IN_W];
            cnt        <= '0;
            bus.oValid <= 1'b1;
            bus.oData  <= pick(head[IN_W-1:0], head[IN_W], '0);
            bus.oLast  <= 1'b0;
        end else if (accept) begin
            if (bus.oLast) begin
                // Drained with nothing queued: oData keeps the last symbol.
                cnt        <= '0;
                bus.oValid <= 1'b0;
                bus.oLast  <= 1'b0;
            end else begin
                cnt       <= cnt + 1'b1;
                bus.oData <= pick(word, msbFirst, cnt + 1'b1);
                bus.oLast <= ((cnt + 1'b1) == CNT_W'(RATIO - 1));
            end
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed + random bench for two serializer configs
// (32/8/4 and 64/16/2). A word-level model predicts every output each cycle;
// literal expectations pin the model on the directed cases.
module tb_word_serializer;
    import serializer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    word_serializer_if #(.IN_W(32), .OUT_W(8),  .DEPTH(4)) ifA ();
    word_serializer_if #(.IN_W(64), .OUT_W(16), .DEPTH(2)) ifB ();

    word_serializer #(.IN_W(32), .OUT_W(8),  .DEPTH(4)) dutA (.clk(clk), .rst(rst), .bus(ifA));
    word_serializer #(.IN_W(64), .OUT_W(16), .DEPTH(2)) dutB (.clk(clk), .rst(rst), .bus(ifB));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- word-level model ----------------
    localparam int P_IN [2] = '{32, 64};
    localparam int P_OUT[2] = '{8, 16};
    localparam int P_D  [2] = '{4, 2};

    logic [63:0] mFw [2][4];
    bit          mFm [2][4];
    int          mCnt[2];
    logic [63:0] sW  [2];
    bit          sM  [2];
    int          sK  [2];
    bit          sV  [2];
    logic [15:0] held[2];

    function automatic logic [15:0] sym(input logic [63:0] w, input bit msb, input int k,
                                        input int iw, input int ow);
        int sh;
        logic [63:0] m;
        sh = msb ? (iw / ow - 1 - k) * ow : k * ow;
        m  = (64'd1 << ow) - 64'd1;
        return 16'((w >> sh) & m);
    endfunction

    function automatic logic [15:0] expSym(input int u);
        if (sV[u]) return sym(sW[u], sM[u], sK[u], P_IN[u], P_OUT[u]);
        return held[u];
    endfunction

    task automatic modelClear(input int u);
        mCnt[u] = 0; sV[u] = 0; sK[u] = 0; held[u] = '0;
    endtask

    task automatic modelStep(input int u, input bit iv, input logic [63:0] d, input bit msb,
                             input bit ordy, input bit fl);
        int  r;
        bit  hs, lastHs, pop, push;
        if (fl) begin
            modelClear(u);
            return;
        end
        r      = P_IN[u] / P_OUT[u];
        hs     = sV[u] && ordy;
        lastHs = hs && (sK[u] == r - 1);
        pop    = (mCnt[u] > 0) && (!sV[u] || lastHs);
        push   = iv && (mCnt[u] != P_D[u]);
        if (hs) begin
            held[u] = expSym(u);
            if (lastHs) begin sV[u] = 0; sK[u] = 0; end
            else sK[u]++;
        end
        if (pop) begin
            sW[u] = mFw[u][0]; sM[u] = mFm[u][0]; sK[u] = 0; sV[u] = 1;
            for (int i = 0; i < 3; i++) begin
                mFw[u][i] = mFw[u][i+1]; mFm[u][i] = mFm[u][i+1];
            end
            mCnt[u]--;
        end
        if (push) begin
            mFw[u][mCnt[u]] = d; mFm[u][mCnt[u]] = msb;
            mCnt[u]++;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            modelClear(0);
            modelClear(1);
        end else begin
            cyc++;
            modelStep(0, ifA.iValid, {32'd0, ifA.iData}, ifA.iMsbFirst, ifA.oReady, ifA.iFlush);
            modelStep(1, ifB.iValid, ifB.iData, ifB.iMsbFirst, ifB.oReady, ifB.iFlush);
        end
    end

    // ---------------- compare + capture ----------------
    logic [16:0] capA[$];
    int          capACyc[$];
    logic [16:0] capB[$];

    always @(negedge clk) begin
        if (rst) begin
            chk("A.oValid", 64'(ifA.oValid), 64'(sV[0]));
            chk("A.oData",  64'(ifA.oData),  64'(expSym(0)));
            chk("A.oLast",  64'(ifA.oLast),  64'(sV[0] && sK[0] == 3));
            chk("A.oLevel", 64'(ifA.oLevel), 64'(mCnt[0]));
            chk("A.iReady", 64'(ifA.iReady), 64'(mCnt[0] != 4));
            chk("B.oValid", 64'(ifB.oValid), 64'(sV[1]));
            chk("B.oData",  64'(ifB.oData),  64'(expSym(1)));
            chk("B.oLast",  64'(ifB.oLast),  64'(sV[1] && sK[1] == 3));
            chk("B.oLevel", 64'(ifB.oLevel), 64'(mCnt[1]));
            chk("B.iReady", 64'(ifB.iReady), 64'(mCnt[1] != 2));
            if (ifA.oValid && ifA.oReady) begin
                capA.push_back({ifA.oLast, 8'd0, ifA.oData});
                capACyc.push_back(cyc);
            end
            if (ifB.oValid && ifB.oReady) capB.push_back({ifB.oLast, ifB.oData});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [7:0]  exp2 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0]  exp3 [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [15:0] exp6 [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};

    initial begin
        int acc;
        ifA.iData = '0; ifA.iMsbFirst = 1'b0; ifA.iValid = 1'b0; ifA.iFlush = 1'b0; ifA.oReady = 1'b0;
        ifB.iData = '0; ifB.iMsbFirst = 1'b0; ifB.iValid = 1'b0; ifB.iFlush = 1'b0; ifB.oReady = 1'b0;

        // Reset state
        #12;
        chk("rst.oValid", 64'(ifA.oValid), 64'd0);
        chk("rst.oData",  64'(ifA.oData),  64'd0);
        chk("rst.oLevel", 64'(ifA.oLevel), 64'd0);
        chk("rst.oLast",  64'(ifA.oLast),  64'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rel.iReadyA", 64'(ifA.iReady), 64'd1);
        chk("rel.iReadyB", 64'(ifB.iReady), 64'd1);

        // MSB-first single word, latency
        tick();
        capA.delete(); capACyc.delete();
        ifA.oReady = 1'b1;
        ifA.iData = 32'hA1B2C3D4; ifA.iMsbFirst = ORDER_MSB; ifA.iValid = 1'b1;
        tick();
        ifA.iValid = 1'b0;
        @(negedge clk);
        chk("lat.E", 64'(ifA.oValid), 64'd0);
        @(negedge clk);
        chk("lat.E1",   64'(ifA.oValid), 64'd1);
        chk("lat.sym0", 64'(ifA.oData),  64'hA1);
        repeat (6) tick();
        chk("t2.count", 64'(capA.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < capA.size()) begin
                chk("t2.sym",  64'(capA[i][7:0]), 64'(exp2[i]));
                chk("t2.last", 64'(capA[i][16]),  64'(i == 3));
            end
        end

        // LSB-first then MSB-first back to back
        capA.delete(); capACyc.delete();
        ifA.iData = 32'h11223344; ifA.iMsbFirst = ORDER_LSB; ifA.iValid = 1'b1;
        tick();
        ifA.iData = 32'h55667788; ifA.iMsbFirst = ORDER_MSB;
        tick();
        ifA.iValid = 1'b0;
        repeat (12) tick();
        chk("t3.count", 64'(capA.size()), 64'd8);
        if (capA.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t3.sym",  64'(capA[i][7:0]), 64'(exp3[i]));
                chk("t3.last", 64'(capA[i][16]),  64'(i == 3 || i == 7));
            end
            chk("t3.nogap", 64'(capACyc[7] - capACyc[0]), 64'd7);
        end

        // Backpressure until full
        ifA.oReady = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            ifA.iData = 32'h10203040 + 32'h01010101 * i;
            ifA.iMsbFirst = ORDER_MSB; ifA.iValid = 1'b1;
            if (ifA.iReady) acc++;
            tick();
        end
        repeat (3) tick();
        chk("t4.accepted", 64'(acc),          64'd5);
        chk("t4.level",    64'(ifA.oLevel),   64'd4);
        chk("t4.iReady",   64'(ifA.iReady),   64'd0);
        chk("t4.oValid",   64'(ifA.oValid),   64'd1);
        chk("t4.oData",    64'(ifA.oData),    64'h10);
        ifA.iValid = 1'b0;
        ifA.oReady = 1'b1;
        repeat (25) tick();
        chk("t4.drained", 64'(ifA.oLevel), 64'd0);

        // Flush mid-word with words queued and a same-cycle push
        ifA.oReady = 1'b0;
        ifA.iData = 32'hDEADBEEF; ifA.iMsbFirst = ORDER_MSB; ifA.iValid = 1'b1;
        tick();
        ifA.iData = 32'h01234567; ifA.iMsbFirst = ORDER_LSB;
        tick();
        ifA.iData = 32'h89ABCDEF; ifA.iMsbFirst = ORDER_MSB;
        tick();
        ifA.iValid = 1'b0;
        tick();
        chk("t5.level", 64'(ifA.oLevel), 64'd2);
        chk("t5.sym0",  64'(ifA.oData),  64'hDE);
        ifA.oReady = 1'b1;
        tick();
        tick();
        chk("t5.sym2", 64'(ifA.oData), 64'hBE);
        ifA.iFlush = 1'b1; ifA.iValid = 1'b1; ifA.iData = 32'hCAFEF00D;
        tick();
        ifA.iFlush = 1'b0; ifA.iValid = 1'b0;
        capA.delete(); capACyc.delete();
        @(negedge clk);
        chk("t5.oValid", 64'(ifA.oValid), 64'd0);
        chk("t5.oLevel", 64'(ifA.oLevel), 64'd0);
        chk("t5.oData",  64'(ifA.oData),  64'd0);
        chk("t5.iReady", 64'(ifA.iReady), 64'd1);
        repeat (8) tick();
        chk("t5.noemit", 64'(capA.size()), 64'd0);

        // 64/16/2 configuration
        capB.delete();
        ifB.oReady = 1'b1;
        ifB.iData = 64'h0123456789ABCDEF; ifB.iMsbFirst = ORDER_MSB; ifB.iValid = 1'b1;
        tick();
        ifB.iValid = 1'b0;
        repeat (6) tick();
        chk("t6.count", 64'(capB.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < capB.size()) begin
                chk("t6.sym",  64'(capB[i][15:0]), 64'(exp6[i]));
                chk("t6.last", 64'(capB[i][16]),   64'(i == 3));
            end
        end

        // Random traffic on both configurations, checked by the model
        for (int n = 0; n < 400; n++) begin
            ifA.iValid = 1'($urandom_range(0, 1)); ifA.iData = $urandom;
            ifA.iMsbFirst = 1'($urandom_range(0, 1));
            ifA.oReady = ($urandom_range(0, 3) != 0); ifA.iFlush = ($urandom_range(0, 31) == 0);
            ifB.iValid = 1'($urandom_range(0, 1)); ifB.iData = {$urandom, $urandom};
            ifB.iMsbFirst = 1'($urandom_range(0, 1));
            ifB.oReady = ($urandom_range(0, 3) != 0); ifB.iFlush = ($urandom_range(0, 31) == 0);
            tick();
        end
        ifA.iValid = 1'b0; ifA.iFlush = 1'b0; ifB.iValid = 1'b0; ifB.iFlush = 1'b0;

        // Asynchronous reset mid-stream
        ifA.oReady = 1'b0;
        ifA.iData = 32'h5A5A0F0F; ifA.iMsbFirst = ORDER_MSB; ifA.iValid = 1'b1;
        tick(); tick(); tick(); tick();
        ifA.iValid = 1'b0;
        tick();
        chk("r1.preValid", 64'(ifA.oValid), 64'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("r1.oValid", 64'(ifA.oValid), 64'd0);
        chk("r1.oData",  64'(ifA.oData),  64'd0);
        chk("r1.oLevel", 64'(ifA.oLevel), 64'd0);
        chk("r1.oLast",  64'(ifA.oLast),  64'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("r1.iReady", 64'(ifA.iReady), 64'd1);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
